mdu_ctrl: RTL and testbench

- Multi-cycle multiply/divide unit controller for the MIPS datapath.
- Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request at a time and latches the operands with signed or zero extension to 64 bits, chosen by the op.
- Holds the unit busy for a fixed latency, then commits the results to the HI/LO registers.
- Sits beside the ALU in the execute stage. The stall logic reads busy.

---
 rtl/mdu_ctrl.sv | 150 +++++++++++++++
 tb/tb_mdu_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller for the MIPS execute stage.
// Latches extended operands, counts a fixed latency, then commits to HI/LO.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [63:0]      a_ext_q, a_ext_d;
  logic [63:0]      b_ext_q, b_ext_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  op_e         op_in;
  logic        idle_req, last_cycle;
  logic        acc_arith, acc_div, acc_signed, acc_mthi, acc_mtlo;
  logic [63:0] prod, divisor;
  logic [31:0] quot, rem;
  logic        div_by_zero;

  assign op_in      = op_e'(op);
  assign idle_req   = start && (state_q == ST_IDLE);
  assign last_cycle = (state_q == ST_RUN) && (cnt_q == CNT_W'(1));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    acc_arith  = 1'b0;
    acc_div    = 1'b0;
    acc_signed = 1'b0;
    acc_mthi   = 1'b0;
    acc_mtlo   = 1'b0;
    if (idle_req) begin
      case (op_in)
        OP_MULT:  begin acc_arith = 1'b1; acc_signed = 1'b1; end
        OP_MULTU: acc_arith = 1'b1;
        OP_DIV:   begin acc_arith = 1'b1; acc_div = 1'b1; acc_signed = 1'b1; end
        OP_DIVU:  begin acc_arith = 1'b1; acc_div = 1'b1; end
        OP_MTHI:  acc_mthi = 1'b1;
        OP_MTLO:  acc_mtlo = 1'b1;
        default:  ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (acc_arith)  state_d = ST_RUN;
      ST_RUN:  if (last_cycle) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_RUN);
  end

  // Operands are pre-extended, so one 64-bit signed datapath serves both signednesses.
  assign prod        = a_ext_q * b_ext_q;
  assign div_by_zero = (b_ext_q == '0);
  assign divisor     = div_by_zero ? 64'd1 : b_ext_q;
  assign quot        = 32'($signed(a_ext_q) / $signed(divisor));
  assign rem         = 32'($signed(a_ext_q) % $signed(divisor));

  always_comb begin
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    a_ext_d  = a_ext_q;
    b_ext_d  = b_ext_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (acc_arith) begin
      a_ext_d  = acc_signed ? {{32{a[31]}}, a} : {32'h0, a};
      b_ext_d  = acc_signed ? {{32{b[31]}}, b} : {32'h0, b};
      is_div_d = acc_div;
      cnt_d    = acc_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (acc_mthi) begin
      hi_d = a;
    end else if (acc_mtlo) begin
      lo_d = a;
    end
    if (state_q == ST_RUN) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (last_cycle) begin
        if (!is_div_q) begin
          {hi_d, lo_d} = prod;
        end else if (!div_by_zero) begin
          lo_d = quot;
          hi_d = rem;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      a_ext_q  <= '0;
      b_ext_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      a_ext_q  <= a_ext_d;
      b_ext_q  <= b_ext_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus random traffic
// compared every cycle against an arithmetic reference model.
module tb_mdu_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op    = 3'd0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        busy;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;
  int busy_obs = 0;

  // Reference model state: architectural HI/LO plus the pending result.
  int          m_left   = 0;
  logic [31:0] m_hi     = '0;
  logic [31:0] m_lo     = '0;
  logic [31:0] p_hi     = '0;
  logic [31:0] p_lo     = '0;
  bit          p_commit = 1'b0;

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_accept(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb);
    longint      pm, sa, sb, q, r;
    logic [63:0] pu;
    p_commit = 1'b1;
    case (o)
      3'd1: begin
        pm = longint'($signed(aa)) * longint'($signed(bb));
        {p_hi, p_lo} = pm;
      end
      3'd2: begin
        pu = 64'(aa) * 64'(bb);
        {p_hi, p_lo} = pu;
      end
      3'd3: begin
        if (bb == 32'h0) p_commit = 1'b0;
        else begin
          sa = longint'($signed(aa));
          sb = longint'($signed(bb));
          q  = sa / sb;
          r  = sa % sb;
          p_lo = q[31:0];
          p_hi = r[31:0];
        end
      end
      default: begin
        if (bb == 32'h0) p_commit = 1'b0;
        else begin
          p_lo = aa / bb;
          p_hi = aa % bb;
        end
      end
    endcase
    m_left = (o <= 3'd2) ? MULT_N : DIV_N;
  endtask

  // One clock: drive request, advance model at the edge, compare just after it.
  task automatic cycle(input bit s, input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb);
    start = s; op = o; a = aa; b = bb;
    @(posedge clk);
    if (m_left > 0) begin
      if (m_left == 1 && p_commit) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
      m_left--;
    end else if (s) begin
      case (o)
        3'd1, 3'd2, 3'd3, 3'd4: model_accept(o, aa, bb);
        3'd5: m_hi = aa;
        3'd6: m_lo = aa;
        default: ;
      endcase
    end
    #1;
    if (busy === 1'b1) busy_obs++;
    check("busy", {31'h0, busy}, {31'h0, (m_left > 0)});
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    start = 1'b0; op = 3'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 3'd0, $urandom, $urandom);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic reset_mid_cycle();
    #2 reset = 1'b1;
    #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    m_left = 0; m_hi = '0; m_lo = '0; p_commit = 1'b0;
    @(negedge clk) reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    @(negedge clk) reset = 1'b0;

    busy_obs = 0;
    cycle(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3);
    idle(6);
    check("mult_busy_len", 32'(busy_obs), 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    cycle(1'b1, 3'd2, 32'hFFFF_FFFF, 32'd2);
    idle(6);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    busy_obs = 0;
    cycle(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2);
    idle(11);
    check("div_busy_len", 32'(busy_obs), 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    cycle(1'b1, 3'd5, 32'h11, 32'h0);
    cycle(1'b1, 3'd6, 32'h22, 32'h0);
    busy_obs = 0;
    cycle(1'b1, 3'd4, 32'd7, 32'd0);
    idle(11);
    check("div0_busy_len", 32'(busy_obs), 32'd10);
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);

    cycle(1'b1, 3'd5, 32'h1234, 32'h0);
    check("mthi_hi", hi, 32'h1234);
    check("mthi_busy", {31'h0, busy}, 32'h0);

    cycle(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(11);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'h0);

    cycle(1'b1, 3'd7, 32'hDEAD, 32'h1);
    cycle(1'b1, 3'd0, 32'hBEEF, 32'h1);
    check("noop_busy", {31'h0, busy}, 32'h0);

    // Start on the committing edge is ignored; the next edge accepts.
    cycle(1'b1, 3'd1, 32'd9, 32'd9);
    idle(4);
    cycle(1'b1, 3'd5, 32'hABCD, 32'h0);
    check("commit_edge_hi", hi, 32'h0);
    cycle(1'b1, 3'd5, 32'hABCD, 32'h0);
    check("after_commit_hi", hi, 32'hABCD);

    reset_mid_cycle();
    cycle(1'b1, 3'd3, 32'd3, 32'd5);
    idle(3);
    cycle(1'b1, 3'd6, 32'h55, 32'h0);
    check("mtlo_busy_lo", lo, 32'h0);
    idle(10);
    check("mtlo_ign_lo", lo, 32'h0);
    check("mtlo_ign_hi", hi, 32'h3);

    cycle(1'b1, 3'd3, 32'd100, 32'd7);
    idle(3);
    reset_mid_cycle();
    cycle(1'b1, 3'd1, 32'd6, 32'd7);
    idle(6);
    check("fresh_lo", lo, 32'd42);
    check("fresh_hi", hi, 32'h0);

    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rand_operand(), rand_operand());
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
